// File: rtl/game_consts_pkg.sv
// game_consts: screen/boss geometry, LFSR seed and boss scheduler state encodings.
package game_consts;
    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;
    localparam int BOSS_W = 16;
    localparam int BOSS_H = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_COUNT  = 3'd2,
        S_SPAWN  = 3'd3,
        S_ENGAGE = 3'd4
    } state_t;
endpackage

// File: rtl/boss_spawn_ctrl_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps every cycle and reloads its seed on reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] q
);
    always_ff @(posedge clk)
        q <= !resetn ? SEED : {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
endmodule

// File: rtl/boss_spawn_ctrl.sv
// boss_spawn_ctrl: schedules boss spawns after a random tick delay and turns player fire into single kill pulses.
module boss_spawn_ctrl
    import game_consts::*;
#(
    parameter int TICK_DIV       = 5000000,
    parameter int MIN_TICKS      = 10,
    parameter int BOSS_W         = game_consts::BOSS_W,
    parameter int BOSS_H         = game_consts::BOSS_H,
    parameter int X_MAX          = game_consts::X_MAX,
    parameter int Y_MAX          = game_consts::Y_MAX,
    parameter int COOLDOWN_TICKS = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       titleoff,
    input  logic       over,
    input  logic       clear,
    input  logic       tar,
    input  logic       fire,
    input  logic [7:0] aim_x,
    input  logic [6:0] aim_y,
    output logic       spawn,
    output logic       kill,
    output logic [7:0] boss_x,
    output logic [6:0] boss_y
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] XLIM = 8'(X_MAX - BOSS_W);
    localparam logic [6:0] YLIM = 7'(Y_MAX - BOSS_H);

    state_t state, state_n;
    logic [15:0] lfsr;
    logic [TW-1:0] tick;
    logic [7:0] delay, cool;
    logic fire_q, kill_done, abort, wrap, hit, accept, unused_ok;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .resetn(resetn), .q(lfsr));

    assign unused_ok = lfsr[7];
    assign abort = !titleoff || over;
    assign wrap = tick == TW'(TICK_DIV - 1);
    // widened by one bit so boss_x+BOSS_W-1 / boss_y+BOSS_H-1 cannot wrap
    assign hit = {1'b0, boss_x} <= {1'b0, aim_x} && {1'b0, aim_x} <= {1'b0, boss_x} + 9'(BOSS_W - 1)
              && {1'b0, boss_y} <= {1'b0, aim_y} && {1'b0, aim_y} <= {1'b0, boss_y} + 8'(BOSS_H - 1);
    assign accept = !abort && state == S_ENGAGE && tar && fire && !fire_q && cool == 8'd0 && !kill_done;

    always_ff @(posedge clk)
        state <= !resetn ? S_IDLE : state_n;

    always_comb begin
        state_n = state;
        spawn = state == S_SPAWN;
        if (abort)
            state_n = S_IDLE;
        else
            case (state)
                S_IDLE:   state_n = clear ? S_ARM : S_IDLE;
                S_ARM:    state_n = S_COUNT;
                S_COUNT:  state_n = delay == 8'd0 ? S_SPAWN : S_COUNT;
                S_SPAWN:  state_n = S_ENGAGE;
                S_ENGAGE: state_n = clear ? S_ARM : S_ENGAGE;
                default:  state_n = S_IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick <= '0;
            delay <= 8'd0;
            cool <= 8'd0;
            fire_q <= 1'b0;
            kill_done <= 1'b0;
            kill <= 1'b0;
            boss_x <= 8'd0;
            boss_y <= 7'd0;
        end else begin
            fire_q <= fire;
            tick <= (state == S_ARM || wrap) ? '0 : tick + TW'(1);
            kill <= accept && hit;
            if (abort) begin
                delay <= 8'd0;
                cool <= 8'd0;
            end else begin
                if (state == S_ARM)
                    delay <= 8'(MIN_TICKS) + {4'd0, lfsr[3:0]};
                else if (state == S_COUNT && wrap && delay != 8'd0)
                    delay <= delay - 8'd1;
                if (accept)
                    cool <= 8'(COOLDOWN_TICKS);
                else if (wrap && cool != 8'd0)
                    cool <= cool - 8'd1;
            end
            if (state == S_ARM)
                kill_done <= 1'b0;
            else if (accept && hit)
                kill_done <= 1'b1;
            if (state == S_SPAWN) begin
                boss_x <= lfsr[15:8] > XLIM ? lfsr[15:8] - XLIM - 8'd1 : lfsr[15:8];
                boss_y <= lfsr[6:0] > YLIM ? lfsr[6:0] - YLIM - 7'd1 : lfsr[6:0];
            end
        end
    end
endmodule

// File: tb/tb_boss_spawn_ctrl.sv
// tb_boss_spawn_ctrl: directed checks of spawn timing, boss placement, hit/cooldown rules, abort and reset.
module tb_boss_spawn_ctrl;
    import game_consts::*;
    localparam int TD = 4;
    localparam int MT = 2;
    localparam int CT = 3;

    logic clk = 0, resetn = 0, titleoff = 0, over = 0, clear = 0, tar = 0, fire = 0;
    logic [7:0] aim_x = 8'd0;
    logic [6:0] aim_y = 7'd0;
    logic spawn, kill;
    logic [7:0] boss_x;
    logic [6:0] boss_y;
    logic [15:0] mlfsr;
    logic [7:0] bx;
    logic [6:0] by;
    int checks = 0, errors = 0;

    boss_spawn_ctrl #(.TICK_DIV(TD), .MIN_TICKS(MT), .COOLDOWN_TICKS(CT)) dut (
        .clk(clk), .resetn(resetn), .titleoff(titleoff), .over(over), .clear(clear), .tar(tar),
        .fire(fire), .aim_x(aim_x), .aim_y(aim_y), .spawn(spawn), .kill(kill),
        .boss_x(boss_x), .boss_y(boss_y)
    );

    always #5 clk = ~clk;

    // reference LFSR: seed 16'hACE1, taps 16,14,13,11
    always @(posedge clk)
        mlfsr <= !resetn ? 16'hACE1 : {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};

    function automatic logic [7:0] fx(input logic [7:0] v);
        return v > 8'd144 ? v - 8'd145 : v;
    endfunction

    function automatic logic [6:0] fy(input logic [6:0] v);
        return v > 7'd104 ? v - 7'd105 : v;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // enters S_ARM on the next edge, then checks spawn timing and the latched position
    task automatic arm_spawn(input string tag);
        int d, hi;
        logic [15:0] s;
        clear = 1; tar = 0; fire = 0;
        step();
        d = MT + int'(mlfsr[3:0]);
        hi = 0;
        for (int i = 0; i < d * TD + 1; i++) begin
            step();
            hi += int'(spawn);
        end
        check({tag, "_early"}, 32'(hi), 32'd0);
        step();
        check({tag, "_spawn"}, 32'(spawn), 32'd1);
        s = mlfsr;
        clear = 0;
        step();
        check({tag, "_pulse"}, 32'(spawn), 32'd0);
        bx = fx(s[15:8]);
        by = fy(s[6:0]);
        check({tag, "_bx"}, 32'(boss_x), 32'(bx));
        check({tag, "_by"}, 32'(boss_y), 32'(by));
        check({tag, "_bx_rng"}, 32'(boss_x <= 8'd144), 32'd1);
        check({tag, "_by_rng"}, 32'(boss_y <= 7'd104), 32'd1);
    endtask

    initial begin
        int hi;
        step(3);
        check("rst_spawn", 32'(spawn), 32'd0);
        check("rst_kill", 32'(kill), 32'd0);
        check("rst_bx", 32'(boss_x), 32'd0);
        check("rst_by", 32'(boss_y), 32'd0);
        check("rst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
        titleoff = 1; resetn = 1;
        arm_spawn("t1");

        tar = 1; aim_x = bx + 8'd15; aim_y = by + 7'd15; fire = 1;
        step();
        check("t2_kill", 32'(kill), 32'd1);
        step();
        check("t2_once", 32'(kill), 32'd0);
        fire = 0;
        step(19);
        fire = 1;
        step();
        check("t2_second", 32'(kill), 32'd0);
        step();
        check("t2_second_late", 32'(kill), 32'd0);
        fire = 0;

        arm_spawn("t3");
        tar = 1; aim_x = bx + 8'd16; aim_y = by; fire = 1;
        step();
        check("t3_miss", 32'(kill), 32'd0);
        fire = 0;
        step(3);
        aim_x = bx; fire = 1;
        step();
        check("t3_cool", 32'(kill), 32'd0);
        step();
        check("t3_cool_late", 32'(kill), 32'd0);
        fire = 0;
        step(8);
        fire = 1;
        step();
        check("t3_after_cool", 32'(kill), 32'd1);
        step();
        check("t3_after_once", 32'(kill), 32'd0);
        fire = 0;

        arm_spawn("t4");
        aim_x = bx + 8'd7; aim_y = by + 7'd7; fire = 1;
        step();
        check("t4_tar0", 32'(kill), 32'd0);
        tar = 1;
        step(2);
        check("t4_held", 32'(kill), 32'd0);
        fire = 0;
        step();
        fire = 1;
        step();
        tar = 0;
        check("t4_tar_fall", 32'(kill), 32'd1);
        step();
        check("t4_once", 32'(kill), 32'd0);
        fire = 0;

        clear = 1;
        step(4);
        titleoff = 0;
        hi = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            hi += int'(spawn);
        end
        check("t5_no_spawn", 32'(hi), 32'd0);
        titleoff = 1;
        arm_spawn("t5");

        tar = 1; aim_x = bx; aim_y = by; fire = 1; over = 1;
        step();
        check("t6_abort_kill", 32'(kill), 32'd0);
        check("t6_abort_idle", 32'(dut.state), 32'(S_IDLE));
        step();
        check("t6_abort_kill_late", 32'(kill), 32'd0);
        over = 0; fire = 0; tar = 0; clear = 1;
        step(5);
        resetn = 0;
        step();
        check("t6_rst_spawn", 32'(spawn), 32'd0);
        check("t6_rst_kill", 32'(kill), 32'd0);
        check("t6_rst_bx", 32'(boss_x), 32'd0);
        check("t6_rst_by", 32'(boss_y), 32'd0);
        check("t6_rst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
        check("t6_rst_state", 32'(dut.state), 32'(S_IDLE));
        resetn = 1;
        arm_spawn("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
